dram_port_arbiter: RTL and testbench

//  Shares the single Dram controller port between two bus masters: port 0 is the cache controller (68k path),

---
 rtl/dram_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dram_port_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares one Dram controller port between two bus masters. Port 0 (cache
//   controller, 68k path) has fixed priority; port 1 (DMA/video) is granted
//   after port 0 has won STARVE_LIMIT contested arbitrations in a row. A grant
//   covers one whole bus cycle (select/AS held low) and is never pre-empted.
//   GAP_CYCLES idle cycles follow each grant so the controller sees AS_L high.
//
// Ports
//   Clock, Reset_H             clock, synchronous active-high reset
//   P0_* / P1_* inputs         select, AS, WE, UDS, LDS, address, write data
//   P0_Dtack_L, P1_Dtack_L     Dtack routed back to the owning master (else 1)
//   Dram* outputs              request signals of the owner, inactive otherwise
//   DtackFromDram_L            Dtack from the Dram controller
//   Grant                      one-hot owner {P1,P0}, 00 = none
//   ArbState                   state encoding, for debug
module dram_port_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int GAP_CYCLES   = 1
) (
   input  logic        Clock,
   input  logic        Reset_H,
   input  logic        P0_Select_L,
   input  logic        P0_AS_L,
   input  logic        P0_WE_L,
   input  logic        P0_UDS_L,
   input  logic        P0_LDS_L,
   input  logic [31:0] P0_Address,
   input  logic [15:0] P0_DataOut,
   output logic        P0_Dtack_L,
   input  logic        P1_Select_L,
   input  logic        P1_AS_L,
   input  logic        P1_WE_L,
   input  logic        P1_UDS_L,
   input  logic        P1_LDS_L,
   input  logic [31:0] P1_Address,
   input  logic [15:0] P1_DataOut,
   output logic        P1_Dtack_L,
   output logic        DramSelect_L,
   output logic        DramAS_L,
   output logic        DramWE_L,
   output logic        DramUDS_L,
   output logic        DramLDS_L,
   output logic [31:0] DramAddress,
   output logic [15:0] DramDataOut,
   input  logic        DtackFromDram_L,
   output logic [1:0]  Grant,
   output logic [1:0]  ArbState
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_GRANT0 = 2'b01,
      ST_GRANT1 = 2'b10,
      ST_GAP    = 2'b11
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
   // Gap counter counts down to zero, so a gap of N cycles loads N-1.
   localparam logic [2:0] GAP_LOAD   = 3'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

   state_t      state_q, state_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic [2:0]  gap_cnt_q, gap_cnt_d;
   logic        req0, req1;

   assign req0 = !P0_Select_L && !P0_AS_L;
   assign req1 = !P1_Select_L && !P1_AS_L;

   // State register with starvation and gap counters
   always_ff @(posedge Clock) begin
      if (Reset_H) begin
         state_q      <= ST_IDLE;
         starve_cnt_q <= 4'd0;
         gap_cnt_q    <= 3'd0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
      end
   end

   // Next-state logic: arbitration only in IDLE, release ends a grant
   always_comb begin
      state_d      = state_q;
      starve_cnt_d = starve_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (req0 && req1) begin
               if (starve_cnt_q >= STARVE_LIM) begin
                  state_d      = ST_GRANT1;
                  starve_cnt_d = 4'd0;
               end else begin
                  state_d = ST_GRANT0;
                  // Port 1 lost a contest: count it, saturating at 15
                  if (starve_cnt_q != 4'd15) begin
                     starve_cnt_d = starve_cnt_q + 4'd1;
                  end else begin
                     starve_cnt_d = starve_cnt_q;
                  end
               end
            end else if (req0) begin
               state_d = ST_GRANT0;
            end else if (req1) begin
               state_d      = ST_GRANT1;
               starve_cnt_d = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT0, ST_GRANT1: begin
            if ((state_q == ST_GRANT0) ? req0 : req1) begin
               state_d = state_q;
            end else if (GAP_CYCLES > 0) begin
               state_d   = ST_GAP;
               gap_cnt_d = GAP_LOAD;
            end else begin
               state_d   = ST_IDLE;
               gap_cnt_d = 3'd0;
            end
         end
         ST_GAP: begin
            if (gap_cnt_q == 3'd0) begin
               state_d = ST_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q - 3'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output mux: owner's signals pass straight through, everything else inactive
   always_comb begin
      DramSelect_L = 1'b1;
      DramAS_L     = 1'b1;
      DramWE_L     = 1'b1;
      DramUDS_L    = 1'b1;
      DramLDS_L    = 1'b1;
      DramAddress  = 32'd0;
      DramDataOut  = 16'd0;
      P0_Dtack_L   = 1'b1;
      P1_Dtack_L   = 1'b1;
      case (state_q)
         ST_GRANT0: begin
            DramSelect_L = P0_Select_L;
            DramAS_L     = P0_AS_L;
            DramWE_L     = P0_WE_L;
            DramUDS_L    = P0_UDS_L;
            DramLDS_L    = P0_LDS_L;
            DramAddress  = P0_Address;
            DramDataOut  = P0_DataOut;
            P0_Dtack_L   = DtackFromDram_L;
         end
         ST_GRANT1: begin
            DramSelect_L = P1_Select_L;
            DramAS_L     = P1_AS_L;
            DramWE_L     = P1_WE_L;
            DramUDS_L    = P1_UDS_L;
            DramLDS_L    = P1_LDS_L;
            DramAddress  = P1_Address;
            DramDataOut  = P1_DataOut;
            P1_Dtack_L   = DtackFromDram_L;
         end
         default: begin
            DramSelect_L = 1'b1;
         end
      endcase
   end

   assign Grant    = {state_q == ST_GRANT1, state_q == ST_GRANT0};
   assign ArbState = state_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter
//   Two arbiter instances share every input: index 0 is built with
//   GAP_CYCLES=1, index 1 with GAP_CYCLES=0. A reference model tracks the
//   owner, remaining gap cycles and starvation count of each instance.
module tb_dram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  sel_l = 2'b11, as_l = 2'b11, we_l = 2'b11, uds_l = 2'b11, lds_l = 2'b11;
   logic [31:0] addr [2];
   logic [15:0] dout [2];
   logic        dtack_from = 1'b1;

   logic [1:0]  grant [2];
   logic [1:0]  arb_state [2];
   logic        d_sel [2], d_as [2], d_we [2], d_uds [2], d_lds [2];
   logic [31:0] d_addr [2];
   logic [15:0] d_data [2];
   logic        p0_dt [2], p1_dt [2];

   int checks = 0;
   int errors = 0;

   // reference model state per instance
   int   m_owner  [2] = '{-1, -1};
   int   m_gap    [2] = '{0, 0};
   int   m_starve [2] = '{0, 0};
   logic m_valid = 1'b0;

   always #5 clk = ~clk;

   dram_port_arbiter #(.STARVE_LIMIT(4), .GAP_CYCLES(1)) u_dut_g1 (
      .Clock(clk), .Reset_H(rst),
      .P0_Select_L(sel_l[0]), .P0_AS_L(as_l[0]), .P0_WE_L(we_l[0]), .P0_UDS_L(uds_l[0]),
      .P0_LDS_L(lds_l[0]), .P0_Address(addr[0]), .P0_DataOut(dout[0]), .P0_Dtack_L(p0_dt[0]),
      .P1_Select_L(sel_l[1]), .P1_AS_L(as_l[1]), .P1_WE_L(we_l[1]), .P1_UDS_L(uds_l[1]),
      .P1_LDS_L(lds_l[1]), .P1_Address(addr[1]), .P1_DataOut(dout[1]), .P1_Dtack_L(p1_dt[0]),
      .DramSelect_L(d_sel[0]), .DramAS_L(d_as[0]), .DramWE_L(d_we[0]), .DramUDS_L(d_uds[0]),
      .DramLDS_L(d_lds[0]), .DramAddress(d_addr[0]), .DramDataOut(d_data[0]),
      .DtackFromDram_L(dtack_from), .Grant(grant[0]), .ArbState(arb_state[0])
   );

   dram_port_arbiter #(.STARVE_LIMIT(4), .GAP_CYCLES(0)) u_dut_g0 (
      .Clock(clk), .Reset_H(rst),
      .P0_Select_L(sel_l[0]), .P0_AS_L(as_l[0]), .P0_WE_L(we_l[0]), .P0_UDS_L(uds_l[0]),
      .P0_LDS_L(lds_l[0]), .P0_Address(addr[0]), .P0_DataOut(dout[0]), .P0_Dtack_L(p0_dt[1]),
      .P1_Select_L(sel_l[1]), .P1_AS_L(as_l[1]), .P1_WE_L(we_l[1]), .P1_UDS_L(uds_l[1]),
      .P1_LDS_L(lds_l[1]), .P1_Address(addr[1]), .P1_DataOut(dout[1]), .P1_Dtack_L(p1_dt[1]),
      .DramSelect_L(d_sel[1]), .DramAS_L(d_as[1]), .DramWE_L(d_we[1]), .DramUDS_L(d_uds[1]),
      .DramLDS_L(d_lds[1]), .DramAddress(d_addr[1]), .DramDataOut(d_data[1]),
      .DtackFromDram_L(dtack_from), .Grant(grant[1]), .ArbState(arb_state[1])
   );

   function automatic logic port_req(input int p);
      return !sel_l[p] && !as_l[p];
   endfunction

   function automatic int gap_of(input int i);
      return (i == 0) ? 1 : 0;
   endfunction

   // Reference model: owner keeps the port while requesting, then a gap, then arbitration
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_owner[i]  <= -1;
            m_gap[i]    <= 0;
            m_starve[i] <= 0;
            m_valid     <= 1'b1;
         end else if (m_owner[i] >= 0) begin
            if (!port_req(m_owner[i])) begin
               m_owner[i] <= -1;
               m_gap[i]   <= gap_of(i);
            end
         end else if (m_gap[i] > 0) begin
            m_gap[i] <= m_gap[i] - 1;
         end else if (port_req(0) && port_req(1)) begin
            if (m_starve[i] >= 4) begin
               m_owner[i]  <= 1;
               m_starve[i] <= 0;
            end else begin
               m_owner[i]  <= 0;
               m_starve[i] <= (m_starve[i] < 15) ? m_starve[i] + 1 : 15;
            end
         end else if (port_req(0)) begin
            m_owner[i] <= 0;
         end else if (port_req(1)) begin
            m_owner[i]  <= 1;
            m_starve[i] <= 0;
         end
      end
   end

   function automatic logic [58:0] model_out(input int i);
      if (m_owner[i] == 0)
         return {2'b01, 2'b01, sel_l[0], as_l[0], we_l[0], uds_l[0], lds_l[0], addr[0], dout[0], dtack_from, 1'b1};
      else if (m_owner[i] == 1)
         return {2'b10, 2'b10, sel_l[1], as_l[1], we_l[1], uds_l[1], lds_l[1], addr[1], dout[1], 1'b1, dtack_from};
      else
         return {2'b00, (m_gap[i] > 0) ? 2'b11 : 2'b00, 5'b11111, 32'd0, 16'd0, 2'b11};
   endfunction

   function automatic logic [58:0] dut_out(input int i);
      return {grant[i], arb_state[i], d_sel[i], d_as[i], d_we[i], d_uds[i], d_lds[i],
              d_addr[i], d_data[i], p0_dt[i], p1_dt[i]};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ports(input int n);
      sel_l = 2'b11; as_l = 2'b11; we_l = 2'b11; uds_l = 2'b11; lds_l = 2'b11;
      dtack_from = 1'b1;
      for (int k = 0; k < n; k++) next_cycle();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sel_l = 2'b00; as_l = 2'b00;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({grant[i], d_sel[i], d_as[i], d_we[i], d_uds[i], d_lds[i], p0_dt[i], p1_dt[i]} !== 9'b00_1111111) begin
               errors++;
               $display("FAIL reset_outputs dut%0d got grant=%b sel=%b as=%b dt=%b%b exp grant=00 strobes=1 dtack=11",
                        i, grant[i], d_sel[i], d_as[i], p0_dt[i], p1_dt[i]);
            end
         end
      end
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (grant[i] !== 2'b01) begin
            errors++;
            $display("FAIL reset_release_grant dut%0d got=%b exp=01", i, grant[i]);
         end
      end
      next_cycle();
   endtask

   task automatic test_p1_read();
      idle_ports(4);
      addr[1] = 32'h0800_0010; we_l[1] = 1'b1; uds_l[1] = 1'b0; lds_l[1] = 1'b0;
      sel_l[1] = 1'b0; as_l[1] = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         if (c == 5) dtack_from = 1'b0;
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (m_valid) begin
               checks++;
               if (dut_out(i) !== model_out(i)) begin
                  errors++;
                  $display("FAIL p1_read_model dut%0d t=%0t got=%h exp=%h", i, $time, dut_out(i), model_out(i));
               end
            end
            checks++;
            if (grant[i] !== 2'b10 || d_addr[i] !== 32'h0800_0010 || p1_dt[i] !== (c < 5) || p0_dt[i] !== 1'b1) begin
               errors++;
               $display("FAIL p1_read dut%0d c=%0d got grant=%b addr=%h dt0=%b dt1=%b exp grant=10 addr=08000010 dt0=1 dt1=%b",
                        i, c, grant[i], d_addr[i], p0_dt[i], p1_dt[i], (c < 5));
            end
         end
      end
      idle_ports(1);
   endtask

   task automatic test_starvation();
      int order[$];
      int exp_order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      int hold = 0;
      int idle_run = 0;
      logic [1:0] prev = 2'b00;
      idle_ports(0);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 300 && order.size() < 10; k++) begin
         if (grant[0] != 2'b00) hold++; else hold = 0;
         sel_l = 2'b00; as_l = 2'b00;
         // owner holds its cycle for three clocks, then releases for one
         if (hold >= 3) begin
            if (grant[0] == 2'b01) as_l[0] = 1'b1; else as_l[1] = 1'b1;
         end
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (m_valid) begin
               checks++;
               if (dut_out(i) !== model_out(i)) begin
                  errors++;
                  $display("FAIL starve_model dut%0d t=%0t got=%h exp=%h", i, $time, dut_out(i), model_out(i));
               end
            end
         end
         if (grant[0] != 2'b00 && prev == 2'b00) begin
            order.push_back((grant[0] == 2'b10) ? 1 : 0);
            if (order.size() > 1) begin
               checks++;
               if (idle_run != 2) begin
                  errors++;
                  $display("FAIL starve_gap_len got=%0d exp=2", idle_run);
               end
            end
            idle_run = 0;
         end
         if (grant[0] == 2'b00) idle_run++;
         prev = grant[0];
         next_cycle();
      end
      checks++;
      if (order.size() != 10) begin
         errors++;
         $display("FAIL starve_timeout got=%0d grants exp=10", order.size());
      end
      for (int n = 0; n < order.size(); n++) begin
         checks++;
         if (order[n] != exp_order[n]) begin
            errors++;
            $display("FAIL starve_order idx=%0d got=%0d exp=%0d", n, order[n], exp_order[n]);
         end
      end
      idle_ports(2);
   endtask

   task automatic test_p0_write();
      logic [1:0] g_exp [2][8] = '{'{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10},
                                   '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10}};
      logic [1:0] s_exp [2][8] = '{'{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b00, 2'b10},
                                   '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10}};
      idle_ports(3);
      addr[0] = $urandom; dout[0] = 16'hBEEF;
      we_l[0] = 1'b0; uds_l[0] = 1'b0; lds_l[0] = 1'b1; sel_l[0] = 1'b0; as_l[0] = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         if (c == 2) begin sel_l[1] = 1'b0; as_l[1] = 1'b0; end
         if (c == 5) begin sel_l[0] = 1'b1; as_l[0] = 1'b1; end
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({grant[i], arb_state[i]} !== {g_exp[i][c-1], s_exp[i][c-1]}) begin
               errors++;
               $display("FAIL p0_write_seq dut%0d c=%0d got grant=%b state=%b exp grant=%b state=%b",
                        i, c, grant[i], arb_state[i], g_exp[i][c-1], s_exp[i][c-1]);
            end
            if (c <= 5) begin
               checks++;
               if ({d_we[i], d_uds[i], d_lds[i], d_data[i]} !== {3'b001, 16'hBEEF}) begin
                  errors++;
                  $display("FAIL p0_write_data dut%0d c=%0d got we/uds/lds=%b%b%b data=%h exp 001 BEEF",
                           i, c, d_we[i], d_uds[i], d_lds[i], d_data[i]);
               end
            end
         end
      end
      idle_ports(3);
   endtask

   task automatic test_reset_mid_grant();
      idle_ports(3);
      sel_l[1] = 1'b0; as_l[1] = 1'b0;
      next_cycle();
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (grant[i] !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_pre dut%0d got=%b exp=10", i, grant[i]);
         end
      end
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if ({grant[i], arb_state[i], d_sel[i], d_as[i], d_addr[i], p0_dt[i], p1_dt[i]} !== {4'b0000, 2'b11, 32'd0, 2'b11}) begin
            errors++;
            $display("FAIL rst_mid_inactive dut%0d got grant=%b state=%b sel=%b as=%b addr=%h exp 00 00 1 1 0",
                     i, grant[i], arb_state[i], d_sel[i], d_as[i], d_addr[i]);
         end
      end
      next_cycle();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (grant[i] !== 2'b10) begin
            errors++;
            $display("FAIL rst_mid_regrant dut%0d got=%b exp=10", i, grant[i]);
         end
      end
      idle_ports(3);
   endtask

   task automatic test_gap0();
      logic [3:0] exp_gs [2][3] = '{'{4'b0011, 4'b0000, 4'b1010},
                                    '{4'b0000, 4'b1010, 4'b1010}};
      idle_ports(3);
      sel_l[0] = 1'b0; as_l[0] = 1'b0;
      next_cycle();
      sel_l = 2'b01; as_l = 2'b01;
      for (int c = 0; c < 3; c++) begin
         next_cycle();
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            checks++;
            if ({grant[i], arb_state[i]} !== exp_gs[i][c]) begin
               errors++;
               $display("FAIL gap0_seq dut%0d c=%0d got grant/state=%b exp=%b", i, c, {grant[i], arb_state[i]}, exp_gs[i][c]);
            end
         end
      end
      idle_ports(3);
   endtask

   task automatic test_random();
      int hold [2] = '{0, 0};
      for (int k = 0; k < 3000; k++) begin
         rst = ($urandom_range(0, 149) == 0);
         dtack_from = $urandom_range(0, 1);
         for (int p = 0; p < 2; p++) begin
            addr[p] = $urandom; dout[p] = 16'($urandom);
            we_l[p] = $urandom_range(0, 1); uds_l[p] = $urandom_range(0, 1); lds_l[p] = $urandom_range(0, 1);
            if (port_req(p) && hold[p] > 0) begin
               hold[p]--;
            end else if (!port_req(p) && $urandom_range(0, 2) == 0) begin
               sel_l[p] = 1'b0; as_l[p] = 1'b0;
               hold[p] = $urandom_range(0, 6);
            end else begin
               // any non-request combination of select and strobe
               {sel_l[p], as_l[p]} = 2'($urandom_range(1, 3));
            end
         end
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (m_valid) begin
               checks++;
               if (dut_out(i) !== model_out(i)) begin
                  errors++;
                  $display("FAIL random_model dut%0d t=%0t got=%h exp=%h", i, $time, dut_out(i), model_out(i));
               end
            end
         end
         next_cycle();
      end
      rst = 1'b0;
      idle_ports(3);
   endtask

   initial begin
      addr[0] = 32'd0; addr[1] = 32'd0; dout[0] = 16'd0; dout[1] = 16'd0;
      next_cycle();
      test_reset();
      test_p1_read();
      test_starvation();
      test_p0_write();
      test_reset_mid_grant();
      test_gap0();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
